// File: rtl/rtc_bus_sequencer.sv
// Fixed-priority arbiter + multiplexed RTC bus-cycle generator: 4*T_PHASE+1 cycles per transfer, grant one edge after sampling.
// No backpressure: requests are level-held until granted, and a granted transfer always runs to Done.
module rtc_bus_sequencer #(
   parameter int unsigned T_PHASE = 4
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [3:0]  Req,
   input  logic [3:0]  Wr_nRd,
   input  logic [31:0] Addr_In,
   input  logic [31:0] Data_In,
   output logic [3:0]  Grant,
   output logic        Done,
   output logic        Busy,
   output logic [7:0]  Data_Out,
   input  logic [7:0]  AD_In,
   output logic [7:0]  AD_Out,
   output logic        AD_OE,
   output logic        A_D,
   output logic        CS_n,
   output logic        RD_n,
   output logic        WR_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_A_STB,
      S_A_HLD,
      S_D_STB,
      S_D_HLD,
      S_DONE
   } state_t;

   localparam logic [7:0] PH_LOAD = 8'(T_PHASE - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  grant_q, grant_d;
   logic        wr_q, wr_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic [7:0]  dout_q, dout_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic [7:0]  ad_out_q, ad_out_d;
   logic        ad_oe_q, ad_oe_d;
   logic        a_d_q, a_d_d;
   logic        cs_n_q, cs_n_d;
   logic        rd_n_q, rd_n_d;
   logic        wr_n_q, wr_n_d;
   logic [1:0]  win;
   logic        found;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      dout_d  = dout_q;
      win     = 2'd0;
      found   = 1'b0;

      case (state_q)
         S_IDLE: begin
            for (int k = 0; k < 4; k++) begin
               if (Req[k] && !found) begin
                  found = 1'b1;
                  win   = 2'(k);
               end
            end
            if (found) begin
               state_d = S_A_STB;
               cnt_d   = PH_LOAD;
               grant_d = 4'b0001 << win;
               wr_d    = Wr_nRd[win];
               addr_d  = Addr_In[{win, 3'b000} +: 8];
               data_d  = Data_In[{win, 3'b000} +: 8];
            end
         end
         S_A_STB, S_A_HLD, S_D_STB, S_D_HLD: begin
            if (cnt_q == 8'd0) begin
               cnt_d = PH_LOAD;
               case (state_q)
                  S_A_STB: state_d = S_A_HLD;
                  S_A_HLD: state_d = S_D_STB;
                  S_D_STB: state_d = S_D_HLD;
                  default: state_d = S_DONE;
               endcase
               // Read data is taken on the final edge of the RD_n-low window.
               if (state_q == S_D_STB && !wr_q) begin
                  dout_d = AD_In;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            grant_d = 4'b0000;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 4'b0000;
         end
      endcase

      // Pin values are decoded from the next state so every pin comes straight from a flop.
      done_d   = 1'b0;
      busy_d   = (state_d != S_IDLE);
      cs_n_d   = 1'b1;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      ad_oe_d  = 1'b0;
      a_d_d    = 1'b1;
      ad_out_d = 8'h00;

      case (state_d)
         S_A_STB: begin
            cs_n_d   = 1'b0;
            a_d_d    = 1'b0;
            wr_n_d   = 1'b0;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_d;
         end
         S_A_HLD: begin
            cs_n_d   = 1'b0;
            a_d_d    = 1'b0;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_d;
         end
         S_D_STB: begin
            cs_n_d = 1'b0;
            if (wr_d) begin
               wr_n_d   = 1'b0;
               ad_oe_d  = 1'b1;
               ad_out_d = data_d;
            end else begin
               rd_n_d = 1'b0;
            end
         end
         S_D_HLD: begin
            cs_n_d   = 1'b0;
            ad_oe_d  = wr_d;
            ad_out_d = wr_d ? data_d : 8'h00;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         grant_q  <= 4'b0000;
         wr_q     <= 1'b0;
         addr_q   <= 8'h00;
         data_q   <= 8'h00;
         dout_q   <= 8'h00;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ad_out_q <= 8'h00;
         ad_oe_q  <= 1'b0;
         a_d_q    <= 1'b1;
         cs_n_q   <= 1'b1;
         rd_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         dout_q   <= dout_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         ad_out_q <= ad_out_d;
         ad_oe_q  <= ad_oe_d;
         a_d_q    <= a_d_d;
         cs_n_q   <= cs_n_d;
         rd_n_q   <= rd_n_d;
         wr_n_q   <= wr_n_d;
      end
   end

   assign Grant    = grant_q;
   assign Done     = done_q;
   assign Busy     = busy_q;
   assign Data_Out = dout_q;
   assign AD_Out   = ad_out_q;
   assign AD_OE    = ad_oe_q;
   assign A_D      = a_d_q;
   assign CS_n     = cs_n_q;
   assign RD_n     = rd_n_q;
   assign WR_n     = wr_n_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: directed scenarios then random traffic, every cycle compared
// against a cycle-offset model of the bus sequence.
module tb_rtc_bus_sequencer;

   localparam int N = 2;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [3:0]  Req = 4'h0;
   logic [3:0]  Wr_nRd = 4'h0;
   logic [31:0] Addr_In = 32'h0;
   logic [31:0] Data_In = 32'h0;
   logic [7:0]  AD_In = 8'h00;
   logic [3:0]  Grant;
   logic        Done;
   logic        Busy;
   logic [7:0]  Data_Out;
   logic [7:0]  AD_Out;
   logic        AD_OE;
   logic        A_D;
   logic        CS_n;
   logic        RD_n;
   logic        WR_n;

   int n_checks = 0;
   int n_err    = 0;
   bit mon_en   = 1'b0;

   rtc_bus_sequencer #(.T_PHASE(N)) dut (
      .Clock(Clock), .Reset(Reset), .Req(Req), .Wr_nRd(Wr_nRd),
      .Addr_In(Addr_In), .Data_In(Data_In), .Grant(Grant), .Done(Done),
      .Busy(Busy), .Data_Out(Data_Out), .AD_In(AD_In), .AD_Out(AD_Out),
      .AD_OE(AD_OE), .A_D(A_D), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: m_c is the cycle number counted from the sample edge (cycle 1 follows it).
   bit       m_act  = 1'b0;
   int       m_c    = 0;
   int       m_w    = 0;
   bit       m_wr   = 1'b0;
   bit [7:0] m_addr = 8'h00;
   bit [7:0] m_data = 8'h00;
   bit [7:0] m_dout = 8'h00;

   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         m_act  = 1'b0;
         m_c    = 0;
         m_dout = 8'h00;
      end else if (m_act) begin
         if (m_c == 3*N && !m_wr) m_dout = AD_In;
         if (m_c == 4*N+1) m_act = 1'b0;
         else m_c++;
      end else if (Req != 4'h0) begin
         for (int k = 3; k >= 0; k--) if (Req[k]) m_w = k;
         m_wr   = Wr_nRd[m_w];
         m_addr = Addr_In[8*m_w +: 8];
         m_data = Data_In[8*m_w +: 8];
         m_act  = 1'b1;
         m_c    = 1;
      end
   end

   always @(negedge Clock) begin
      logic [3:0] e_grant;
      logic [7:0] e_out;
      logic e_done, e_busy, e_cs, e_rd, e_wr, e_oe, e_ad, chk_ad, chk_out;
      int ph;
      if (mon_en) begin
         e_grant = 4'h0; e_done = 1'b0; e_busy = 1'b0; e_cs = 1'b1; e_rd = 1'b1;
         e_wr = 1'b1; e_oe = 1'b0; e_ad = 1'b1; e_out = 8'h00;
         chk_ad = 1'b1; chk_out = !Reset;
         if (Reset && m_act) begin
            e_grant = 4'b0001 << m_w;
            e_busy  = 1'b1;
            if (m_c == 4*N+1) begin
               e_done = 1'b1;
               chk_ad = 1'b0;
            end else begin
               ph   = (m_c - 1) / N;
               e_cs = 1'b0;
               e_ad = (ph >= 2);
               if (ph < 2) begin
                  e_oe = 1'b1; e_out = m_addr; e_wr = (ph != 0);
               end else if (m_wr) begin
                  e_oe = 1'b1; e_out = m_data; e_wr = (ph != 2);
               end else begin
                  e_rd = (ph != 2);
               end
               chk_out = e_oe;
            end
         end
         check("grant", Grant, e_grant);
         check("done", Done, e_done);
         check("busy", Busy, e_busy);
         check("cs_n", CS_n, e_cs);
         check("rd_n", RD_n, e_rd);
         check("wr_n", WR_n, e_wr);
         check("ad_oe", AD_OE, e_oe);
         check("data_out", Data_Out, m_dout);
         if (chk_ad) check("a_d", A_D, e_ad);
         if (chk_out) check("ad_out", AD_Out, e_out);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 40) begin
         @(negedge Clock);
         n++;
         if (Done === 1'b1) break;
      end
      check("done_seen", Done, 1'b1);
   endtask

   int n;

   initial begin
      // Reset held with requests toggling
      #1 Reset = 1'b0;
      #1 mon_en = 1'b1;
      Req = 4'hF;
      step(1); Req = 4'h0;
      step(1); Req = 4'hF;
      step(1);
      check("rst_grant", Grant, 4'h0);
      check("rst_busy", Busy, 1'b0);
      Req = 4'h0;
      Reset = 1'b1;
      step(3);

      // Single write, requester 2
      Wr_nRd = 4'b0100; Addr_In[23:16] = 8'h21; Data_In[23:16] = 8'h37;
      Req = 4'b0100;
      step(1); Req = 4'h0;
      wait_done(n);
      check("wr_done_cycle", n, 4*N+1);
      @(negedge Clock);
      check("wr_busy_fall", Busy, 1'b0);
      step(2);

      // Single read, requester 1, then a write must leave Data_Out alone
      Wr_nRd = 4'b0000; Addr_In[15:8] = 8'h42; AD_In = 8'h5A;
      Req = 4'b0010;
      step(1); Req = 4'h0;
      wait_done(n);
      check("rd_done_cycle", n, 4*N+1);
      check("rd_data", Data_Out, 8'h5A);
      step(1);
      AD_In = 8'h00; Wr_nRd = 4'b1000; Addr_In[31:24] = 8'h0C; Data_In[31:24] = 8'hE1;
      Req = 4'b1000;
      step(1); Req = 4'h0;
      wait_done(n);
      check("rd_hold_after_wr", Data_Out, 8'h5A);
      step(2);

      // Contention between requesters 0 and 3
      Wr_nRd = 4'b1001; Addr_In = 32'h33_00_00_30; Data_In = 32'hD3_00_00_D0;
      Req = 4'b1001;
      step(1); Req = 4'b1000;
      wait_done(n);
      check("cont_first", Grant, 4'b0001);
      @(negedge Clock);
      check("cont_idle", Grant, 4'b0000);
      @(negedge Clock);
      check("cont_second", Grant, 4'b1000);
      Req = 4'h0;
      wait_done(n);
      check("cont_second_done", n, 4*N);
      step(2);

      // Inputs changed during A_HLD are ignored
      Wr_nRd = 4'b0010; Addr_In[15:8] = 8'h11; Data_In[15:8] = 8'h99;
      Req = 4'b0010;
      step(1);
      repeat (N+1) @(negedge Clock);
      Req = 4'h0; Addr_In = $urandom; Data_In = $urandom; Wr_nRd = 4'h0;
      wait_done(n);
      check("mid_done_cycle", n, 3*N);
      step(2);

      // Async reset during D_STB of a write
      Wr_nRd = 4'b0100; Addr_In[23:16] = 8'h5C; Data_In[23:16] = 8'hA5;
      Req = 4'b0100;
      step(1); Req = 4'h0;
      repeat (2*N+1) @(negedge Clock);
      check("pre_arst_wr_n", WR_n, 1'b0);
      #3 Reset = 1'b0;
      #1;
      check("arst_cs_n", CS_n, 1'b1);
      check("arst_wr_n", WR_n, 1'b1);
      check("arst_ad_oe", AD_OE, 1'b0);
      check("arst_grant", Grant, 4'h0);
      step(1);
      Reset = 1'b1;
      Req = 4'b0100;
      step(1); Req = 4'h0;
      wait_done(n);
      check("restart_done_cycle", n, 4*N+1);
      step(2);

      // Random traffic with occasional async resets
      for (int i = 0; i < 800; i++) begin
         for (int k = 0; k < 4; k++) Req[k] = ($urandom_range(0, 3) == 0);
         Wr_nRd  = 4'($urandom);
         Addr_In = $urandom;
         Data_In = $urandom;
         AD_In   = 8'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            #2 Reset = 1'b0;
            #1;
            check("rnd_arst_cs_n", CS_n, 1'b1);
            check("rnd_arst_grant", Grant, 4'h0);
            step(1);
            Reset = 1'b1;
         end else begin
            step(1);
         end
      end
      Req = 4'h0;
      step(4*N+4);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Arbiter and bus-cycle generator for the shared RTC parallel port (multiplexed address/data, A/D select, CS/RD/WR strobes). It accepts single-byte read or write requests from four RTC sub-machines: initialization, read, clock/date/timer programming and button programming. It grants one requester at a time by fixed priority and generates the complete strobe sequence with programmable phase width. It sits between the general RTC control FSM's sub-machines and the RTC pins, and replaces per-machine pin muxing.

## Interface
- T_PHASE, 4, clock cycles per bus phase; legal values are 1..255.
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  4  per-requester transaction request, level-sensitive. Bit 0 is highest priority.
- Wr_nRd  in  4  per-requester direction: 1 = write, 0 = read.
- Addr_In  in  32  four 8-bit RTC register addresses; requester k uses bits [8k+7:8k].
- Data_In  in  32  four 8-bit write data bytes, same packing as Addr_In.
- Grant  out  4  one-hot grant, held from transaction start through the Done cycle.
- Done  out  1  one-cycle pulse at transaction end; qualified by Grant.
- Busy  out  1  high in every state except IDLE.
- Data_Out  out  8  last byte read from the RTC.
- AD_In  in  8  RTC bus input from the pad.
- AD_Out  out  8  RTC bus output to the pad.
- AD_OE  out  1  pad output enable for AD_Out.
- A_D  out  1  0 = address phase, 1 = data phase.
- CS_n, RD_n, WR_n  out  1 each  active-low RTC strobes.

## Operation
- States: IDLE, A_STB, A_HLD, D_STB, D_HLD, DONE.
- IDLE:
  - All strobes high, AD_OE=0, A_D=1.
  - If any Req bit is high, select the lowest-index active bit as the winner.
  - Latch the winner's address, data and direction into internal registers.
  - Set the Grant bit for the winner and go to A_STB.
- A_STB: CS_n=0, A_D=0, WR_n=0, AD_OE=1, AD_Out=latched address.
- A_HLD: CS_n=0, A_D=0, WR_n=1, AD_OE=1, AD_Out=address.
- D_STB, write: CS_n=0, A_D=1, WR_n=0, AD_OE=1, AD_Out=latched data.
- D_STB, read: CS_n=0, A_D=1, RD_n=0, AD_OE=0. On the last cycle of the phase, Data_Out<=AD_In.
- D_HLD: CS_n=0, A_D=1, RD_n=WR_n=1. AD_OE=1 on write, 0 on read.
- DONE: CS_n=1, AD_OE=0, Done=1, Grant still held. Go to IDLE the next cycle and clear Grant.
- Each phase state (A_STB through D_HLD) lasts exactly T_PHASE cycles.
  - A down-counter loads T_PHASE-1 on phase entry and advances the state at 0.
  - Counter width is 8 bits.
- Requester inputs are sampled only in IDLE. Changes to Req, Addr, Data or Wr_nRd after the grant are ignored and the transaction always completes.
- A requester still holding Req after Done is re-arbitrated in IDLE against the other requesters. There is no fairness beyond fixed priority.
- Data_Out holds its value across writes and changes only on read completion.
- Reset (low) at any time forces IDLE immediately with all outputs at their reset values.
  - No partial transaction resumes after reset.
  - The RTC sees a strobe abort.

## Timing
- Reset values: Grant=0, Done=0, Busy=0, Data_Out=0x00, AD_Out=0x00, AD_OE=0, A_D=1, CS_n=1, RD_n=1, WR_n=1.
- Edge 0 is the edge at which IDLE samples Req. Grant and A_STB outputs are valid after edge 0.
- A_STB occupies cycles 1..N, A_HLD occupies N+1..2N, D_STB occupies 2N+1..3N and D_HLD occupies 3N+1..4N, where N=T_PHASE.
- Done is high in cycle 4N+1.
- For back-to-back transactions, IDLE lasts one cycle. The next grant is valid at cycle 4N+3 after the previous sample edge, giving a period of 4N+2.
- Outputs are registered or decoded from registered state only, with no combinational path from Req to pins. Grant may be decoded from a registered winner.
- Read data is captured at the end of cycle 3N, i.e. the RD_n low window ends one phase before Done.

## Test plan
- Reset check: hold Reset low, toggle Req=4'hF, then release Reset. All outputs must stay at their reset values until the first sample edge.
- Single write, T_PHASE=2: requester 2 asserts Req with Addr=0x21 and Data=0x37.
  - Grant=4'b0100 is valid from cycle 1.
  - WR_n is low in cycles 1-2 with A_D=0 and AD_Out=0x21.
  - WR_n is low in cycles 5-6 with A_D=1 and AD_Out=0x37.
  - Done is high in cycle 9 and Busy falls in cycle 10.
- Single read, T_PHASE=2: requester 1 reads Addr=0x42 with AD_In=0x5A.
  - RD_n is low in cycles 5-6 with AD_OE=0.
  - Data_Out=0x5A from cycle 7 onward.
  - A following write leaves Data_Out at 0x5A.
- Contention: Req[0] and Req[3] assert in the same cycle. Requester 0 completes first, then Grant=4'b1000 one IDLE cycle after Done.
- Mid-transaction changes: drop Req[1] and change Addr_In during A_HLD. The transaction finishes with the original address and Done still pulses.
- Async reset during D_STB of a write: CS_n, WR_n and AD_OE return to reset values without waiting for a Clock edge. Grant=0, and a new request after release restarts from A_STB.
